channel_readout_arbiter: RTL and testbench
==========================================

Name: channel_readout_arbiter

Overview:
Round-robin arbiter that shares the single event-FIFO write port among the 64 analog channels. A channel raises a request when its ADC conversion finishes. The arbiter grants one channel per clock and returns a one-cycle ack to it. It then writes a packed event word {channel id, timestamp, ADC code} toward the FIFO. It sits in digital_core between the per-channel ADC done/dout outputs and the event FIFO, and applies backpressure through fifo_full.

Parameters:
NUMCHANNELS, 64, number of requesting channels
ADCBITS, 10, ADC code width per channel
CHAN_ID_W, 6, channel index width; equals clog2(NUMCHANNELS)
TS_W, 28, timestamp counter width
STALL_W, 16, stall counter width

Ports:
clk  input  1  master clock
reset_n  input  1  asynchronous digital reset (active low)
enable  input  1  high permits grants
req  input  NUMCHANNELS  per-channel level request; held until acked
chan_data  input  ADCBITS*NUMCHANNELS  channel n code at [n*ADCBITS +: ADCBITS]; stable while req[n] high
fifo_full  input  1  high blocks all grants this cycle
ack  output  NUMCHANNELS  one-hot, one-cycle grant acknowledge
event_valid  output  1  one-cycle FIFO write strobe
event_word  output  CHAN_ID_W+TS_W+ADCBITS  packed as {chan_id, timestamp, adc_code}, MSB to LSB
timestamp  output  TS_W  free-running time counter
stall_count  output  STALL_W  saturating count of blocked cycles

Behaviour:
- Reset (async, reset_n low):
  - ack=0, event_valid=0, event_word=0, timestamp=0, stall_count=0.
  - Internal last_grant=NUMCHANNELS-1, so channel 0 holds first priority after reset.
- Timestamp:
  - Increments by 1 every clk, independent of enable.
  - Wraps from 2^TS_W-1 to 0.
- Eligible set: eff_req = req & ~ack.
  - The channel acked in the current cycle is masked. This prevents a double grant while that channel drops req.
- Grant condition: enable & ~fifo_full & |eff_req.
- Grant selection:
  - g = first set bit of eff_req, searching upward from last_grant+1 with wrap modulo NUMCHANNELS.
  - Pure combinational priority rotation; no extra latency.
- On a rising edge where the grant condition is true:
  - ack <= onehot(g).
  - event_valid <= 1.
  - event_word <= {g, timestamp (pre-edge value), chan_data[g]}.
  - last_grant <= g.
- On any other edge:
  - ack <= 0 and event_valid <= 0.
  - event_word holds its last value.
  - last_grant unchanged.
- Latency: a request sampled at edge N produces ack and event_valid high in the cycle following edge N.
- Throughput: 1 event/cycle sustained with two or more requesters. A single persistent requester is served at most every other cycle because of the ack mask.
- Requester contract:
  - Channel deasserts req[n] at or before the edge after ack[n] rises.
  - req still high one cycle later is treated as a new request.
- Backpressure:
  - fifo_full is sampled at the same edge as the grant; there is no write while it is high.
  - A pending request is never lost; it remains in req.
- stall_count:
  - Increments by 1 on each edge where enable & fifo_full & |eff_req.
  - Saturates at 2^STALL_W-1; cleared only by reset.
- enable low: no grants and no stall counting. last_grant is retained, so fairness resumes where it stopped.
- Simultaneous requests on all 64 channels: served in strict rotation, with a worst-case wait of NUMCHANNELS cycles absent backpressure.
- Reset mid-operation:
  - All outputs clear immediately, including any in-flight ack or event_valid.
  - Priority returns to channel 0.

Test Plan:
- Reset, enable=1, req=64'h1 held; drop req one cycle after ack -> ack[0] and event_valid high in cycle 1; event_word chan_id=0, adc=chan_data[9:0], timestamp=0; exactly one event.
- req bits 3, 7, 40 set simultaneously, each dropped after its ack -> grants in order 3, 7, 40 on consecutive cycles; chan_id fields 3, 7, 40; timestamps differ by 1.
- All 64 req high, each dropped after ack -> 64 events in order 0..63 over 64 consecutive cycles; no duplicates; event_valid continuously high.
- req=bit 5, fifo_full=1 for 10 cycles, then 0 -> no ack or event_valid during the stall; stall_count=10; single grant to channel 5 on the cycle after fifo_full falls.
- Single requester holding req[9] high indefinitely -> ack[9] alternates 1,0,1,0; event_valid every other cycle.
- Timestamp preset near wrap by running 2^TS_W cycles (or forcing), then a grant -> event_word timestamp equals the pre-edge counter value; the counter wraps to 0.
- reset_n pulsed low during a grant cycle -> ack, event_valid and stall_count go to 0 immediately; the next grant favours the lowest requesting index.

Source files
------------

// File: rtl/channel_readout_arbiter_if.sv
// Bundle between the channel array, the arbiter and the event FIFO write port.
// The master side is the environment (channels raising req, FIFO reporting full);
// the slave side is the arbiter that acks channels and writes events.
interface channel_readout_arbiter_if #(
    parameter int NUMCHANNELS = 64,
    parameter int ADCBITS     = 10,
    parameter int CHAN_ID_W   = 6,
    parameter int TS_W        = 28
);
    localparam int EVENT_W = CHAN_ID_W + TS_W + ADCBITS;

    logic [NUMCHANNELS-1:0]         req;
    logic [ADCBITS*NUMCHANNELS-1:0] chan_data;
    logic                           fifo_full;
    logic [NUMCHANNELS-1:0]         ack;
    logic                           event_valid;
    logic [EVENT_W-1:0]             event_word;

    modport master (
        output req, chan_data, fifo_full,
        input  ack, event_valid, event_word
    );

    modport slave (
        input  req, chan_data, fifo_full,
        output ack, event_valid, event_word
    );
endinterface

// File: rtl/channel_readout_arbiter.sv
// Round-robin arbiter sharing the event-FIFO write port among the ADC channels.
// One grant per clock; the granted channel gets a one-cycle ack and its packed
// event {chan_id, timestamp, adc_code} is strobed toward the FIFO.
module channel_readout_arbiter #(
    parameter int NUMCHANNELS = 64,
    parameter int ADCBITS     = 10,
    parameter int CHAN_ID_W   = 6,
    parameter int TS_W        = 28,
    parameter int STALL_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    channel_readout_arbiter_if.slave bus,
    output logic [TS_W-1:0]          timestamp,
    output logic [STALL_W-1:0]       stall_count
);
    localparam int EVENT_W = CHAN_ID_W + TS_W + ADCBITS;

    logic [NUMCHANNELS-1:0] ack_q;
    logic                   event_valid_q;
    logic [EVENT_W-1:0]     event_word_q;
    logic [CHAN_ID_W-1:0]   last_grant;

    logic [NUMCHANNELS-1:0] eff_req;
    logic [CHAN_ID_W-1:0]   grant_idx;
    logic                   grant_found;
    logic [ADCBITS-1:0]     grant_code;
    logic                   do_grant;
    logic                   do_stall;

    // The channel being acked this cycle is still holding req; mask it so it
    // cannot win twice while it drops its request.
    assign eff_req  = bus.req & ~ack_q;
    assign do_grant = enable & ~bus.fifo_full & grant_found;
    assign do_stall = enable & bus.fifo_full & (|eff_req);

    assign bus.ack         = ack_q;
    assign bus.event_valid = event_valid_q;
    assign bus.event_word  = event_word_q;

    // Rotating priority search: first eligible channel above last_grant, wrapping.
    always_comb begin
        int                   cand;
        logic [CHAN_ID_W-1:0] cand_idx;
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUMCHANNELS; i++) begin
            cand = int'(last_grant) + 1 + i;
            if (cand >= NUMCHANNELS) begin
                cand = cand - NUMCHANNELS;
            end
            cand_idx = CHAN_ID_W'(cand);
            if (!grant_found && eff_req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // ADC code of the channel currently selected by the search.
    assign grant_code = bus.chan_data[int'(grant_idx)*ADCBITS +: ADCBITS];

    // Free-running timestamp and saturating backpressure counter.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timestamp   <= '0;
            stall_count <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
            if (do_stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    // Grant register: ack, FIFO write strobe, event word and rotation pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q         <= '0;
            event_valid_q <= 1'b0;
            event_word_q  <= '0;
            last_grant    <= CHAN_ID_W'(NUMCHANNELS - 1);
        end else if (do_grant) begin
            ack_q         <= NUMCHANNELS'(1) << grant_idx;
            event_valid_q <= 1'b1;
            event_word_q  <= {grant_idx, timestamp, grant_code};
            last_grant    <= grant_idx;
        end else begin
            ack_q         <= '0;
            event_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Scoreboard bench for channel_readout_arbiter: directed stimulus pushes the
// expected events, a negedge monitor pops and compares each presented event.
module tb_channel_readout_arbiter;
    localparam int NUMCHANNELS = 64;
    localparam int ADCBITS     = 10;
    localparam int CHAN_ID_W   = 6;
    localparam int TS_W        = 28;
    localparam int STALL_W     = 16;

    typedef struct {
        int                 chan;
        logic [TS_W-1:0]    ts;
        logic [ADCBITS-1:0] adc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [TS_W-1:0]    timestamp;
    logic [STALL_W-1:0] stall_count;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              n_events = 0;
    int              cyc      = 0;
    logic [TS_W-1:0] ts_off   = '0;
    bit              auto_drop = 1'b1;
    int              ev0;

    channel_readout_arbiter_if #(
        .NUMCHANNELS(NUMCHANNELS), .ADCBITS(ADCBITS),
        .CHAN_ID_W(CHAN_ID_W), .TS_W(TS_W)
    ) bus ();

    channel_readout_arbiter #(
        .NUMCHANNELS(NUMCHANNELS), .ADCBITS(ADCBITS), .CHAN_ID_W(CHAN_ID_W),
        .TS_W(TS_W), .STALL_W(STALL_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .bus(bus),
        .timestamp(timestamp),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; expected timestamp = cyc + ts_off.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [TS_W-1:0] ts_now();
        return TS_W'(cyc) + ts_off;
    endfunction

    function automatic logic [ADCBITS-1:0] adc_of(input int n);
        return ADCBITS'((n * 37 + 5) % 1024);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic push_exp(input int ch, input int dts);
        exp_q.push_back('{chan: ch, ts: ts_now() + TS_W'(dts), adc: adc_of(ch)});
    endtask

    // Advance to the next negedge; a compliant channel drops req once acked.
    task automatic tick();
        @(negedge clk);
        if (auto_drop) bus.req = bus.req & ~bus.ack;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (4) tick();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        bus.req   = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ts_off  = '0;
    endtask

    // Monitor: every presented event must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (bus.event_valid || (bus.ack != '0))) begin
            n_events++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got word %0h ack %0h expected no event",
                         bus.event_word, bus.ack);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_word", 64'(bus.event_word),
                      64'({CHAN_ID_W'(e.chan), e.ts, e.adc}));
                check("ack_onehot", bus.ack, 64'(1) << e.chan);
                check("event_valid", 64'(bus.event_valid), 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        for (int n = 0; n < NUMCHANNELS; n++) begin
            bus.chan_data[n*ADCBITS +: ADCBITS] = adc_of(n);
        end
        repeat (2) @(negedge clk);
        check("rst_ack", bus.ack, 64'd0);
        check("rst_valid", 64'(bus.event_valid), 64'd0);
        check("rst_word", 64'(bus.event_word), 64'd0);
        check("rst_ts", 64'(timestamp), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);

        // Single requester on channel 0 right after reset.
        bus.req = 64'h1;
        push_exp(0, 0);
        ev0 = n_events;
        reset_n = 1'b1;
        drain("t1", 10);
        check("t1_events", 64'(n_events - ev0), 64'd1);

        // Three simultaneous requesters served in index order.
        bus.req = (64'(1) << 3) | (64'(1) << 7) | (64'(1) << 40);
        push_exp(3, 0);
        push_exp(7, 1);
        push_exp(40, 2);
        drain("t2", 10);

        // All channels at once after reset: strict rotation 0..63.
        do_reset();
        bus.req = '1;
        ev0 = n_events;
        for (int i = 0; i < NUMCHANNELS; i++) push_exp(i, i);
        drain("t3", 80);
        check("t3_events", 64'(n_events - ev0), 64'd64);

        // Backpressure for ten edges, then a single grant to channel 5.
        bus.req = 64'(1) << 5;
        bus.fifo_full = 1'b1;
        ev0 = n_events;
        repeat (10) tick();
        check("t4_stall", 64'(stall_count), 64'd10);
        check("t4_no_valid", 64'(bus.event_valid), 64'd0);
        bus.fifo_full = 1'b0;
        push_exp(5, 0);
        drain("t4", 10);
        check("t4_events", 64'(n_events - ev0), 64'd1);
        check("t4_stall_hold", 64'(stall_count), 64'd10);

        // Persistent requester: ack alternates every other cycle.
        auto_drop = 1'b0;
        bus.req = 64'(1) << 9;
        for (int i = 0; i < 8; i += 2) push_exp(9, i);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_ack9", 64'(bus.ack[9]), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        bus.req = '0;
        auto_drop = 1'b1;
        drain("t5", 10);

        // Timestamp near wrap: event carries the pre-edge value, counter wraps.
        force dut.timestamp = 28'hFFF_FFFE;
        ts_off = 28'hFFF_FFFE - TS_W'(cyc);
        bus.req = 64'(1) << 2;
        push_exp(2, 0);
        #1 release dut.timestamp;
        tick();
        check("t6_ts_max", 64'(timestamp), 64'hFFF_FFFF);
        tick();
        check("t6_ts_wrap", 64'(timestamp), 64'd0);
        drain("t6", 10);

        // Reset pulsed while an ack is in flight; priority returns to channel 0.
        bus.req = (64'(1) << 20) | (64'(1) << 50);
        push_exp(20, 0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("t7_ack", bus.ack, 64'd0);
        check("t7_valid", 64'(bus.event_valid), 64'd0);
        check("t7_stall", 64'(stall_count), 64'd0);
        check("t7_ts", 64'(timestamp), 64'd0);
        bus.req = (64'(1) << 10) | (64'(1) << 50);
        @(negedge clk);
        reset_n = 1'b1;
        ts_off  = '0;
        push_exp(10, 0);
        push_exp(50, 1);
        drain("t7", 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
